pwm_capture: RTL and testbench



---
 rtl/pwm_capture.sv | 102 ++++++++++
 tb/tb_pwm_capture.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures the period and high time of an asynchronous PWM input
// in clk cycles, publishing once per period and flagging a line that stops toggling.
module pwm_capture #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high,
  output logic             valid,
  output logic             stuck,
  output logic             level
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic             s1;
  logic             s2;
  logic             prev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_lat;
  logic             rise;
  logic             fall;
  logic             quiet;

  // Sync and edge flops idle high, so a line already high at reset release gives no rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= pwm_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise  = s2 & ~prev;
  assign fall  = ~s2 & prev;
  // An edge in the saturating cycle takes priority over the timeout.
  assign quiet = (cnt == CNT_MAX) & ~rise & ~fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      high_lat <= '0;
      period   <= '0;
      high     <= '0;
      valid    <= 1'b0;
      stuck    <= 1'b0;
      level    <= 1'b0;
    end else begin
      // NOTE: later non-blocking assignments in this block override these defaults.
      valid <= 1'b0;
      if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;

      if (state != IDLE && quiet) begin
        stuck <= 1'b1;
        level <= s2;
        state <= s2 ? IDLE : ARM;
      end else begin
        unique case (state)
          IDLE: begin
            cnt <= '0;
            if (!prev) state <= ARM;
          end
          ARM: begin
            if (rise) begin
              cnt   <= CNT_ONE;
              state <= HIGH;
            end
          end
          HIGH: begin
            // cnt keeps running through the fall so period stays rise-to-rise.
            if (fall) begin
              high_lat <= cnt;
              state    <= LOW;
            end
          end
          LOW: begin
            if (rise) begin
              period <= cnt;
              high   <= high_lat;
              valid  <= 1'b1;
              stuck  <= 1'b0;
              cnt    <= CNT_ONE;
              state  <= HIGH;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized and directed PWM waveforms checked against a
// timestamp-based reference model of the capture rules.
module tb_pwm_capture;

  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pwm_in;
  logic [CW-1:0] period;
  logic [CW-1:0] high;
  logic          valid;
  logic          stuck;
  logic          level;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int            edge_n;
    logic [CW-1:0] per;
    logic [CW-1:0] hi;
  } ev_t;

  ev_t exp_q[$];
  ev_t got_q[$];

  bit m_last;
  bit m_rise_ok;
  bit m_fall_ok;
  int m_rise_k;
  int m_fall_k;

  pwm_capture #(.CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pwm_in(pwm_in),
    .period(period),
    .high  (high),
    .valid (valid),
    .stuck (stuck),
    .level (level)
  );

  always #5 clk = ~clk;

  // Reference model: timestamps of sampled line transitions. A rise sampled at
  // edge k publishes at edge k+2 if a rise and a fall precede it within range.
  initial begin : monitor
    ev_t e;
    bit  s;
    bit  exp_v;
    forever begin
      @(posedge clk);
      cyc++;
      s = pwm_in;
      if (!rst_n) begin
        m_last    = 1'b1;
        m_rise_ok = 1'b0;
        m_fall_ok = 1'b0;
        exp_q.delete();
      end else begin
        if (s != m_last && m_rise_ok && (cyc - m_rise_k) > MAXC) begin
          m_rise_ok = 1'b0;
          m_fall_ok = 1'b0;
        end
        if (s && !m_last) begin
          if (m_rise_ok && m_fall_ok) begin
            e.edge_n = cyc + 2;
            e.per    = CW'(cyc - m_rise_k);
            e.hi     = CW'(m_fall_k - m_rise_k);
            exp_q.push_back(e);
          end
          m_rise_ok = 1'b1;
          m_fall_ok = 1'b0;
          m_rise_k  = cyc;
        end else if (!s && m_last && m_rise_ok) begin
          m_fall_ok = 1'b1;
          m_fall_k  = cyc;
        end
        m_last = s;
      end

      @(negedge clk);
      if (rst_n) begin
        exp_v = (exp_q.size() > 0) && (exp_q[0].edge_n == cyc);
        checks++;
        if (valid !== exp_v) begin
          errors++;
          $display("FAIL valid_strobe edge %0d: got %b want %b", cyc, valid, exp_v);
        end
        if (exp_v) begin
          checks++;
          if (period !== exp_q[0].per || high !== exp_q[0].hi) begin
            errors++;
            $display("FAIL measurement edge %0d: got period %0d high %0d want period %0d high %0d",
                     cyc, period, high, exp_q[0].per, exp_q[0].hi);
          end
          void'(exp_q.pop_front());
        end
        if (valid === 1'b1) got_q.push_back('{cyc, period, high});
      end
    end
  end

  task automatic drive(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic v);
    pwm_in = v;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({period, high, valid, stuck, level} !== '0) begin
      errors++;
      $display("FAIL reset_async: got %h want 0", {period, high, valid, stuck, level});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({period, high, valid, stuck, level} !== '0) begin
      errors++;
      $display("FAIL reset_held: got %h want 0", {period, high, valid, stuck, level});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_steady;
    int rk[6];
    got_q.delete();
    drive(1'b0, 6);
    for (int p = 0; p < 6; p++) begin
      rk[p] = cyc + 1;
      drive(1'b1, 4);
      drive(1'b0, 8);
    end
    checks++;
    if (got_q.size() != 5) begin
      errors++;
      $display("FAIL steady_count: got %0d want 5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_q[i].edge_n != rk[i+1] + 2 || got_q[i].per !== 8'd12 || got_q[i].hi !== 8'd4) begin
          errors++;
          $display("FAIL steady_%0d: got edge %0d %0d/%0d want edge %0d 12/4",
                   i, got_q[i].edge_n, got_q[i].per, got_q[i].hi, rk[i+1] + 2);
        end
        if (i > 0) begin
          checks++;
          if (got_q[i].edge_n - got_q[i-1].edge_n != 12) begin
            errors++;
            $display("FAIL steady_spacing_%0d: got %0d want 12", i, got_q[i].edge_n - got_q[i-1].edge_n);
          end
        end
      end
    end
  endtask

  task automatic test_high_at_reset;
    int r2;
    do_reset(1'b1);
    got_q.delete();
    drive(1'b1, 3);
    drive(1'b0, 5);
    drive(1'b1, 4);
    drive(1'b0, 8);
    r2 = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4);
      drive(1'b0, 8);
    end
    drive(1'b1, 2);
    drive(1'b0, 2);
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL high_at_reset_count: got %0d want 3", got_q.size());
    end else begin
      checks++;
      if (got_q[0].edge_n != r2 + 2 || got_q[0].per !== 8'd12 || got_q[0].hi !== 8'd4) begin
        errors++;
        $display("FAIL high_at_reset_first: got edge %0d %0d/%0d want edge %0d 12/4",
                 got_q[0].edge_n, got_q[0].per, got_q[0].hi, r2 + 2);
      end
    end
  endtask

  task automatic test_extreme;
    do_reset(1'b0);
    got_q.delete();
    drive(1'b0, 4);
    repeat (4) begin drive(1'b1, 1);  drive(1'b0, 11); end
    repeat (4) begin drive(1'b1, 11); drive(1'b0, 1);  end
    drive(1'b1, 3);
    drive(1'b0, 3);
    checks++;
    if (got_q.size() != 8) begin
      errors++;
      $display("FAIL extreme_count: got %0d want 8", got_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_q[i].per !== 8'd12 || got_q[i].hi !== ((i < 4) ? 8'd1 : 8'd11)) begin
          errors++;
          $display("FAIL extreme_%0d: got %0d/%0d want 12/%0d", i, got_q[i].per, got_q[i].hi, (i < 4) ? 1 : 11);
        end
      end
    end
  endtask

  task automatic test_duty_change;
    do_reset(1'b0);
    got_q.delete();
    drive(1'b0, 4);
    repeat (3) begin drive(1'b1, 4); drive(1'b0, 8); end
    repeat (3) begin drive(1'b1, 6); drive(1'b0, 4); end
    drive(1'b1, 2);
    drive(1'b0, 2);
    checks++;
    if (got_q.size() != 6) begin
      errors++;
      $display("FAIL duty_count: got %0d want 6", got_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_q[i].per !== ((i < 3) ? 8'd12 : 8'd10) || got_q[i].hi !== ((i < 3) ? 8'd4 : 8'd6)) begin
          errors++;
          $display("FAIL duty_%0d: got %0d/%0d want %0d/%0d", i, got_q[i].per, got_q[i].hi,
                   (i < 3) ? 12 : 10, (i < 3) ? 4 : 6);
        end
      end
    end
  endtask

  task automatic test_async_reset;
    int rb;
    do_reset(1'b0);
    drive(1'b0, 4);
    repeat (2) begin drive(1'b1, 4); drive(1'b0, 8); end
    drive(1'b1, 2);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({period, high, valid, stuck, level} !== '0) begin
      errors++;
      $display("FAIL async_reset_mid_high: got %h want 0", {period, high, valid, stuck, level});
    end
    @(negedge clk);
    @(negedge clk);
    got_q.delete();
    rst_n = 1'b1;
    drive(1'b1, 2);
    drive(1'b0, 8);
    drive(1'b1, 4);
    drive(1'b0, 8);
    checks++;
    if (got_q.size() != 0 || period !== 8'd0 || high !== 8'd0) begin
      errors++;
      $display("FAIL async_reset_arm: got %0d valids period %0d high %0d want 0 0 0", got_q.size(), period, high);
    end
    rb = cyc + 1;
    drive(1'b1, 4);
    drive(1'b0, 2);
    checks++;
    if (got_q.size() != 1 || got_q[0].edge_n != rb + 2 || got_q[0].per !== 8'd12 || got_q[0].hi !== 8'd4) begin
      errors++;
      $display("FAIL async_reset_first_valid: got %0d valids want 1 at edge %0d with 12/4", got_q.size(), rb + 2);
    end
  endtask

  task automatic test_stuck_low;
    int rk;
    int fk;
    do_reset(1'b0);
    drive(1'b0, 4);
    drive(1'b1, 4);
    drive(1'b0, 8);
    rk = cyc + 1;
    drive(1'b1, 4);
    fk = cyc + 1;
    pwm_in = 1'b0;
    while (cyc < rk + 256) @(negedge clk);
    checks++;
    if (stuck !== 1'b0) begin
      errors++;
      $display("FAIL stuck_low_early: got stuck %b want 0", stuck);
    end
    while (cyc < fk + 257) @(negedge clk);
    checks++;
    if (stuck !== 1'b1 || level !== 1'b0 || period !== 8'd12 || high !== 8'd4) begin
      errors++;
      $display("FAIL stuck_low_set: got stuck %b level %b %0d/%0d want 1 0 12/4", stuck, level, period, high);
    end
    while (cyc < fk + 299) @(negedge clk);
    got_q.delete();
    drive(1'b1, 4);
    drive(1'b0, 8);
    drive(1'b1, 1);
    checks++;
    if (stuck !== 1'b1 || got_q.size() != 0) begin
      errors++;
      $display("FAIL stuck_low_hold: got stuck %b valids %0d want 1 0", stuck, got_q.size());
    end
    drive(1'b1, 3);
    drive(1'b0, 2);
    checks++;
    if (stuck !== 1'b0 || got_q.size() != 1 || got_q[0].per !== 8'd12 || got_q[0].hi !== 8'd4) begin
      errors++;
      $display("FAIL stuck_low_clear: got stuck %b valids %0d want 0 1 with 12/4", stuck, got_q.size());
    end
  endtask

  task automatic test_stuck_high;
    int rk;
    do_reset(1'b0);
    drive(1'b0, 4);
    drive(1'b1, 4);
    drive(1'b0, 8);
    rk = cyc + 1;
    pwm_in = 1'b1;
    while (cyc < rk + 256) @(negedge clk);
    checks++;
    if (stuck !== 1'b0) begin
      errors++;
      $display("FAIL stuck_high_early: got stuck %b want 0", stuck);
    end
    @(negedge clk);
    checks++;
    if (stuck !== 1'b1 || level !== 1'b1 || period !== 8'd12 || high !== 8'd4) begin
      errors++;
      $display("FAIL stuck_high_set: got stuck %b level %b %0d/%0d want 1 1 12/4", stuck, level, period, high);
    end
    while (cyc < rk + 300) @(negedge clk);
    got_q.delete();
    drive(1'b0, 8);
    drive(1'b1, 4);
    drive(1'b0, 8);
    drive(1'b1, 1);
    checks++;
    if (stuck !== 1'b1 || got_q.size() != 0) begin
      errors++;
      $display("FAIL stuck_high_hold: got stuck %b valids %0d want 1 0", stuck, got_q.size());
    end
    drive(1'b1, 3);
    drive(1'b0, 2);
    checks++;
    if (stuck !== 1'b0 || got_q.size() != 1 || got_q[0].per !== 8'd12 || got_q[0].hi !== 8'd4) begin
      errors++;
      $display("FAIL stuck_high_clear: got stuck %b valids %0d want 0 1 with 12/4", stuck, got_q.size());
    end
  endtask

  task automatic test_random;
    int hs[30];
    int ls[30];
    do_reset(1'b0);
    got_q.delete();
    drive(1'b0, 4);
    for (int i = 0; i < 30; i++) begin
      hs[i] = $urandom_range(1, 20);
      ls[i] = $urandom_range(1, 20);
      drive(1'b1, hs[i]);
      drive(1'b0, ls[i]);
    end
    drive(1'b1, 2);
    drive(1'b0, 3);
    checks++;
    if (got_q.size() != 30) begin
      errors++;
      $display("FAIL random_count: got %0d want 30", got_q.size());
    end else begin
      for (int i = 0; i < 30; i++) begin
        checks++;
        if (got_q[i].per !== CW'(hs[i] + ls[i]) || got_q[i].hi !== CW'(hs[i])) begin
          errors++;
          $display("FAIL random_%0d: got %0d/%0d want %0d/%0d", i, got_q[i].per, got_q[i].hi, hs[i] + ls[i], hs[i]);
        end
      end
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    pwm_in = 1'b0;
    test_reset;
    test_steady;
    test_high_at_reset;
    test_extreme;
    test_duty_change;
    test_async_reset;
    test_stuck_low;
    test_stuck_high;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
